io_bus_arbiter: RTL and testbench

//   Shares the external I/O port bus (io_data/io_addr/io_oe/io_we) between N requesters,
//   for example the CPU's memory-mapped I/O path and a debug/DMA loader.

---
 rtl/io_bus_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/io_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared I/O bus types and widths
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    XFER = 2'd2,
    TURN = 2'd3
  } bus_state_e;

  localparam int IO_ADDR_W = 4;
  localparam int IO_DATA_W = 8;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last owner
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Search order last+1 .. last+N_REQ, wrapping modulo N_REQ.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int s = 1; s <= N_REQ; s++) begin
      cand = IDX_W'((int'(last) + s) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin owner of the external I/O bus
// Each transaction runs ADDR, XFER, then TURN_CYC cycles of bus release.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = IO_ADDR_W,
  parameter int DATA_W   = IO_DATA_W,
  parameter int TURN_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  inout  wire  [DATA_W-1:0]       io_data,
  output logic [ADDR_W-1:0]       io_addr,
  output logic                    io_oe,
  output logic                    io_we
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = $clog2(TURN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_CYC - 1);

  bus_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands are captured on the IDLE->ADDR edge so requesters may change them once granted.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = ADDR;
          owner_d = arb_idx;
          we_d    = req_we[arb_idx];
          addr_d  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
        end
      end
      ADDR: state_d = XFER;
      XFER: begin
        state_d = TURN;
        cnt_d   = CNT_LOAD;
        last_d  = owner_q;
        if (!we_q) begin
          rdata_d = io_data;
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    done    = '0;
    io_oe   = 1'b0;
    io_we   = 1'b0;
    io_addr = addr_q;
    rdata   = rdata_q;
    case (state_q)
      ADDR: begin
        gnt[owner_q] = 1'b1;
        io_oe        = we_q;
      end
      XFER: begin
        gnt[owner_q] = 1'b1;
        io_oe        = we_q;
        io_we        = we_q;
      end
      TURN: begin
        if (cnt_q == CNT_LOAD) begin
          done[owner_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign io_data = io_oe ? wdata_q : {DATA_W{1'bz}};

  logic unused_arb;
  assign unused_arb = ^arb_gnt;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - scoreboard bench for io_bus_arbiter (3 requesters, 3 turnaround cycles)
module tb_io_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int T  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata;
  wire  [DW-1:0]   io_data;
  logic [AW-1:0]   io_addr;
  logic            io_oe, io_we;

  logic [DW-1:0]   dev_mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          owner;
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  txn_t rec;
  int   k;
  int   last;
  logic [7:0] rdata_m;
  logic [3:0] addr_m;

  io_bus_arbiter #(
    .N_REQ    (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TURN_CYC (T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .io_data   (io_data),
    .io_addr   (io_addr),
    .io_oe     (io_oe),
    .io_we     (io_we)
  );

  // Read-only device: answers whenever a granted transaction leaves the bus free.
  assign io_data = (|gnt && !io_oe) ? dev_mem[io_addr] : 8'hzz;

  initial forever #5 clk = ~clk;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_gnt(input logic [N-1:0] mask);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk);
      #1;
      if ((gnt & mask) != '0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gnt_wait actual=timeout required=grant mask=%b", mask);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: one transaction at a time, fair rotation after the last served requester.
  initial begin
    k = -1; last = N - 1; rdata_m = '0; addr_m = '0;
    cur = '{owner: 0, we: 1'b0, addr: 4'h0, wdata: 8'h00, rdata: 8'h00};
    forever begin
      @(posedge clk);
      if (!reset) begin
        k = -1; last = N - 1; rdata_m = '0; addr_m = '0;
        exp_q.delete();
      end else if (k < 0) begin
        for (int s = 1; s <= N; s++) begin
          int c;
          c = (last + s) % N;
          if (k < 0 && req[c]) begin
            cur.owner = c;
            cur.we    = req_we[c];
            cur.addr  = req_addr[c*AW +: AW];
            cur.wdata = req_wdata[c*DW +: DW];
            cur.rdata = dev_mem[cur.addr];
            addr_m    = cur.addr;
            exp_q.push_back(cur);
            k = 0;
          end
        end
      end else begin
        if (k == 1 && !cur.we) rdata_m = cur.rdata;
        if (k == 2) last = cur.owner;
        if (k == 1 + T) k = -1;
        else k++;
      end
    end
  end

  // Monitor: per-cycle bus shape plus queue-based completion checking.
  initial forever begin
    logic [N-1:0] e_gnt, e_done;
    logic e_oe, e_we;
    @(negedge clk);
    if (!reset) begin
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_oe", 32'(io_oe), 32'h0);
      chk("rst_we", 32'(io_we), 32'h0);
      chk("rst_addr", 32'(io_addr), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
    end else begin
      e_gnt  = (k == 0 || k == 1) ? onehot(cur.owner) : '0;
      e_oe   = (k == 0 || k == 1) && cur.we;
      e_we   = (k == 1) && cur.we;
      e_done = (k == 2) ? onehot(cur.owner) : '0;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("io_oe", 32'(io_oe), 32'(e_oe));
      chk("io_we", 32'(io_we), 32'(e_we));
      chk("done", 32'(done), 32'(e_done));
      chk("io_addr", 32'(io_addr), 32'(addr_m));
      chk("rdata", 32'(rdata), 32'(rdata_m));
      if (io_oe && exp_q.size() > 0) chk("io_data_drv", 32'(io_data), 32'(exp_q[0].wdata));
      if (io_we) begin
        if (exp_q.size() == 0) chk("we_without_txn", 32'(io_we), 32'h0);
        else begin
          chk("we_addr", 32'(io_addr), 32'(exp_q[0].addr));
          chk("we_data", 32'(io_data), 32'(exp_q[0].wdata));
        end
      end
      if (done != '0) begin
        if (exp_q.size() == 0) chk("done_without_txn", 32'(done), 32'h0);
        else begin
          rec = exp_q.pop_front();
          chk("done_owner", 32'(done), 32'(onehot(rec.owner)));
          if (!rec.we) chk("done_rdata", 32'(rdata), 32'(rec.rdata));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) dev_mem[i] = 8'($urandom);
    dev_mem[12] = 8'h5A;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single write from requester 0.
    set_op(0, 1'b1, 4'h3, 8'hA5);
    req[0] = 1'b1;
    wait_gnt(3'b001);
    req[0] = 1'b0;
    idle_cycles(8);

    // Single read from requester 1; the value must persist afterwards.
    set_op(1, 1'b0, 4'hC, 8'h00);
    req[1] = 1'b1;
    wait_gnt(3'b010);
    req[1] = 1'b0;
    idle_cycles(8);
    chk("rdata_hold", 32'(rdata), 32'h5A);

    // Full contention with everyone holding req.
    for (int i = 0; i < N; i++) set_op(i, 1'($urandom_range(1)), 4'($urandom), 8'($urandom));
    req = '1;
    idle_cycles(45);
    req = '0;
    idle_cycles(10);

    // Requester 0 appears during requester 1's transfer and withdraws before IDLE.
    set_op(1, 1'b0, 4'h5, 8'h00);
    req[1] = 1'b1;
    wait_gnt(3'b010);
    req[1] = 1'b0;
    @(posedge clk);
    #1 set_op(0, 1'b1, 4'h9, 8'h77);
    req[0] = 1'b1;
    @(posedge clk);
    #1 req[0] = 1'b0;
    idle_cycles(10);

    // Reset in the middle of a write.
    set_op(0, 1'b1, 4'h7, 8'h3C);
    req[0] = 1'b1;
    wait_gnt(3'b001);
    req[0] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h0);
    chk("async_rst_oe", 32'(io_oe), 32'h0);
    chk("async_rst_we", 32'(io_we), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    req = '1;
    wait_gnt('1);
    chk("first_after_reset", 32'(gnt), 32'h1);
    req = '0;
    idle_cycles(12);

    // Random traffic: late operand changes, withdrawals, drops after grant, re-queues.
    repeat (3000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          set_op(i, 1'($urandom_range(1)), 4'($urandom), 8'($urandom));
          if ($urandom_range(1) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          set_op(i, 1'($urandom_range(1)), 4'($urandom), 8'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    idle_cycles(15);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
